fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 16-bit MIPS pipeline: the producer side of the program counter. Owns the PC register, issues instruction-memory reads over a valid/ready request channel, accepts responses, and drives the IF/ID pipeline register toward decode. It honours stalls from the hazard unit and redirects (branch/jump) from EX, discarding wrong-path fetches.

## Interface
- PC_W, 32, PC and address width
- INSTR_W, 16, instruction width
- RESET_PC, 0, PC value after reset
- PC_STEP, 2, byte increment per instruction
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  PC_W  read address (= pc)
- imem_rsp_valid  in  1  read data valid
- imem_rsp_data  in  INSTR_W  instruction word
- stall  in  1  decode stalled; IF/ID holds
- redirect_valid  in  1  branch taken / jump
- redirect_target  in  PC_W  new fetch address
- ifid_valid  out  1  IF/ID holds a valid instruction
- ifid_instr  out  INSTR_W  fetched instruction
- ifid_pc  out  PC_W  address of ifid_instr
- ifid_pc_plus  out  PC_W  ifid_pc + PC_STEP

## Operation
- States: REQ, WAIT, HOLD. Reset state REQ; one outstanding request max.
- REQ: imem_req_valid=1, imem_req_addr=pc. On valid&ready latch req_pc<=pc, go WAIT. Memory samples addr only on valid&ready.
- WAIT: imem_req_valid=0. On imem_rsp_valid:
  - discard flag set: drop data, clear flag, go REQ.
  - stall=0: load IF/ID (instr, req_pc, req_pc+PC_STEP, valid=1), pc<=req_pc+PC_STEP, go REQ.
  - stall=1: store data in skid register, pc<=req_pc+PC_STEP, go HOLD.
- HOLD: imem_req_valid=0; when stall=0 move skid into IF/ID, go REQ.
- stall=1 with no load: IF/ID holds all fields unchanged.
- stall=0 with no load pending: ifid_valid<=0 (bubble).
- Redirect (highest priority, overrides stall): pc<=redirect_target, ifid_valid<=0, skid invalidated. WAIT: set discard flag, stay WAIT. REQ/HOLD: go REQ. Request accepted in the same cycle as redirect: go WAIT with discard set.
- Response arriving and redirect in same cycle: response dropped, discard not set, go REQ.
- imem_rsp_valid outside WAIT is ignored (late response after reset).
- Arithmetic: pc+PC_STEP modulo 2^PC_W; 0xFFFFFFFE+2 wraps to 0.

## Timing
- Reset (async assert, sync release): pc=RESET_PC, state REQ, discard=0, skid empty, ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pc_plus=0; imem_req_valid=0 while rst high.
- Zero-wait memory (ready=1, rsp one cycle after accept): request cycle N, response N+1, ifid_valid at N+2; one instruction per 2 cycles.
- Redirect at edge N: request to redirect_target issued cycle N+1 (from REQ).
- Redirect in WAIT: next request issued the cycle after the discarded response.
- Reset mid-WAIT/HOLD: all state lost; fetch restarts at RESET_PC.

## Structure
- Package fetch_pkg: state enum (REQ, WAIT, HOLD), default RESET_PC and PC_STEP constants.
- Sub-module fetch_skid_reg: one-entry holding register (instr, pc, pc_plus, valid) with load/clear; everything else in fetch_stage.

## Test plan
- Reset, ready=1, 1-cycle memory returning 0x1111, 0x2222 -> ifid_pc 0x0 then 0x2, ifid_valid every second cycle, ifid_pc_plus 0x2/0x4.
- stall=1 for 4 cycles while response 0x3333 arrives -> IF/ID unchanged, state HOLD, no new request; on stall=0 ifid_instr=0x3333, ifid_pc=0x4.
- redirect_valid with target 0x0100 while in WAIT -> response for old pc dropped, ifid_valid=0, next imem_req_addr=0x0100.
- imem_req_ready=0 for 3 cycles -> imem_req_valid held, addr stable; accepted on 4th, IF/ID loads one cycle after response.
- RESET_PC=0xFFFFFFFE -> first ifid_pc_plus=0x0, second request addr 0x0.
- rst asserted mid-WAIT, late imem_rsp_valid after release -> ignored, first request addr RESET_PC, ifid_valid stays 0 until its response.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned DEF_PC_W     = 32;
  localparam int unsigned DEF_INSTR_W  = 16;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEF_PC_STEP  = 2;

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry holding register for a response that arrives while decode is stalled.
module fetch_skid_reg
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W    = DEF_PC_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [PC_W-1:0]    i_pc_plus,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc,
  output logic [PC_W-1:0]    o_pc_plus
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_pc_plus;

  // Clear wins so a redirect in the same cycle never leaves a stale entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_pc      <= '0;
      r_pc_plus <= '0;
    end else if (i_clear) begin
      r_valid   <= 1'b0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_instr   <= i_instr;
      r_pc      <= i_pc;
      r_pc_plus <= i_pc_plus;
    end
  end

  assign o_valid   = r_valid;
  assign o_instr   = r_instr;
  assign o_pc      = r_pc;
  assign o_pc_plus = r_pc_plus;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem read at a time, fills IF/ID.
//   state   | meaning
//   ST_REQ  | request for pc presented, waiting for ready
//   ST_WAIT | request accepted, waiting for response (may be marked for discard)
//   ST_HOLD | response parked in skid register while decode is stalled
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = DEF_PC_W,
  parameter int unsigned     INSTR_W  = DEF_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC),
  parameter int unsigned     PC_STEP  = DEF_PC_STEP
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [PC_W-1:0]    ifid_pc_plus
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  fetch_state_e r_state, w_next_state;
  logic [PC_W-1:0]    r_pc, r_req_pc, w_pc_next, w_req_pc_plus;
  logic               r_discard, w_next_discard;
  logic               r_ifid_valid;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic [PC_W-1:0]    r_ifid_pc, r_ifid_pc_plus;

  logic               w_req_fire, w_rsp_in;
  logic               w_ifid_from_rsp, w_ifid_from_skid;
  logic               w_skid_load, w_skid_clear;
  logic               w_skid_valid;
  logic [INSTR_W-1:0] w_skid_instr;
  logic [PC_W-1:0]    w_skid_pc, w_skid_pc_plus;

  assign w_req_fire    = (r_state == ST_REQ) && imem_req_ready;
  assign w_rsp_in      = (r_state == ST_WAIT) && imem_rsp_valid;
  assign w_req_pc_plus = r_req_pc + STEP;

  always_comb begin
    w_next_state     = r_state;
    w_next_discard   = r_discard;
    w_ifid_from_rsp  = 1'b0;
    w_ifid_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = redirect_valid;
    case (r_state)
      ST_REQ: begin
        if (w_req_fire) begin
          w_next_state = ST_WAIT;
          // The address just issued is already wrong-path if a redirect lands now.
          if (redirect_valid) w_next_discard = 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_rsp_in) begin
          w_next_state   = ST_REQ;
          w_next_discard = 1'b0;
          if (!redirect_valid && !r_discard) begin
            if (!stall) begin
              w_ifid_from_rsp = 1'b1;
            end else begin
              w_skid_load  = 1'b1;
              w_next_state = ST_HOLD;
            end
          end
        end else if (redirect_valid) begin
          w_next_discard = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          w_next_state = ST_REQ;
        end else if (!stall) begin
          w_ifid_from_skid = w_skid_valid;
          w_skid_clear     = 1'b1;
          w_next_state     = ST_REQ;
        end
      end
      default: begin
        w_next_state   = ST_REQ;
        w_next_discard = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_pc_next = r_pc;
    if (redirect_valid)                        w_pc_next = redirect_target;
    else if (w_skid_load || w_ifid_from_rsp)   w_pc_next = w_req_pc_plus;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_REQ;
      r_discard <= 1'b0;
      r_pc      <= RESET_PC;
      r_req_pc  <= '0;
    end else begin
      r_state   <= w_next_state;
      r_discard <= w_next_discard;
      r_pc      <= w_pc_next;
      if (w_req_fire) r_req_pc <= r_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifid_valid   <= 1'b0;
      r_ifid_instr   <= '0;
      r_ifid_pc      <= '0;
      r_ifid_pc_plus <= '0;
    end else if (redirect_valid) begin
      r_ifid_valid   <= 1'b0;
    end else if (w_ifid_from_rsp) begin
      r_ifid_valid   <= 1'b1;
      r_ifid_instr   <= imem_rsp_data;
      r_ifid_pc      <= r_req_pc;
      r_ifid_pc_plus <= w_req_pc_plus;
    end else if (w_ifid_from_skid) begin
      r_ifid_valid   <= 1'b1;
      r_ifid_instr   <= w_skid_instr;
      r_ifid_pc      <= w_skid_pc;
      r_ifid_pc_plus <= w_skid_pc_plus;
    end else if (!stall) begin
      r_ifid_valid   <= 1'b0;
    end
  end

  fetch_skid_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_skid_load),
    .i_clear   (w_skid_clear),
    .i_instr   (imem_rsp_data),
    .i_pc      (r_req_pc),
    .i_pc_plus (w_req_pc_plus),
    .o_valid   (w_skid_valid),
    .o_instr   (w_skid_instr),
    .o_pc      (w_skid_pc),
    .o_pc_plus (w_skid_pc_plus)
  );

  assign imem_req_valid = (r_state == ST_REQ) && !rst;
  assign imem_req_addr  = r_pc;
  assign ifid_valid     = r_ifid_valid;
  assign ifid_instr     = r_ifid_instr;
  assign ifid_pc        = r_ifid_pc;
  assign ifid_pc_plus   = r_ifid_pc_plus;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage; a second instance covers PC wraparound.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        stall, redir;
  logic [31:0] redir_tgt;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [31:0] if_pc, if_plus;

  logic        rst_b, req_valid_b, req_ready_b, rsp_valid_b;
  logic [31:0] req_addr_b;
  logic [15:0] rsp_data_b;
  logic        if_valid_b;
  logic [15:0] if_instr_b;
  logic [31:0] if_pc_b, if_plus_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .stall(stall), .redirect_valid(redir), .redirect_target(redir_tgt),
    .ifid_valid(if_valid), .ifid_instr(if_instr), .ifid_pc(if_pc), .ifid_pc_plus(if_plus)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFE)) dut_wrap (
    .clk(clk), .rst(rst_b),
    .imem_req_valid(req_valid_b), .imem_req_ready(req_ready_b), .imem_req_addr(req_addr_b),
    .imem_rsp_valid(rsp_valid_b), .imem_rsp_data(rsp_data_b),
    .stall(1'b0), .redirect_valid(1'b0), .redirect_target(32'h0),
    .ifid_valid(if_valid_b), .ifid_instr(if_instr_b), .ifid_pc(if_pc_b), .ifid_pc_plus(if_plus_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    stall = 1'b0; redir = 1'b0; redir_tgt = '0;
    tick(); tick();
    vectors++;
    if ({req_valid, if_valid, if_instr, if_pc, if_plus} !== {1'b0, 1'b0, 16'h0, 32'h0, 32'h0}) begin
      $display("FAIL reset_state: got req_valid=%b ifid=%b/%h/%h/%h want 0/0/0/0/0", req_valid, if_valid, if_instr, if_pc, if_plus);
      miscompares++;
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({req_valid, req_addr} !== {1'b1, 32'h0}) begin
      $display("FAIL reset_first_req: got %b/%h want 1/00000000", req_valid, req_addr);
      miscompares++;
    end
  endtask

  task automatic test_stream();
    tick();
    rsp_valid = 1'b1; rsp_data = 16'h1111;
    vectors++;
    if (req_valid !== 1'b0) begin
      $display("FAIL stream_wait_no_req: got %b want 0", req_valid); miscompares++;
    end
    tick();
    rsp_valid = 1'b0;
    vectors++;
    if ({if_valid, if_instr, if_pc, if_plus, req_valid, req_addr} !== {1'b1, 16'h1111, 32'h0, 32'h2, 1'b1, 32'h2}) begin
      $display("FAIL stream_first: got %b/%h/%h/%h req %b/%h want 1/1111/0/2 req 1/2", if_valid, if_instr, if_pc, if_plus, req_valid, req_addr);
      miscompares++;
    end
    tick();
    rsp_valid = 1'b1; rsp_data = 16'h2222;
    vectors++;
    if (if_valid !== 1'b0) begin
      $display("FAIL stream_bubble: got %b want 0", if_valid); miscompares++;
    end
    tick();
    rsp_valid = 1'b0;
    vectors++;
    if ({if_valid, if_instr, if_pc, if_plus} !== {1'b1, 16'h2222, 32'h2, 32'h4}) begin
      $display("FAIL stream_second: got %b/%h/%h/%h want 1/2222/2/4", if_valid, if_instr, if_pc, if_plus);
      miscompares++;
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    tick();
    rsp_valid = 1'b1; rsp_data = 16'h3333;
    tick();
    rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({if_valid, if_instr, if_pc, if_plus, req_valid} !== {1'b1, 16'h2222, 32'h2, 32'h4, 1'b0}) begin
        $display("FAIL stall_hold[%0d]: got %b/%h/%h/%h req %b want 1/2222/2/4 req 0", i, if_valid, if_instr, if_pc, if_plus, req_valid);
        miscompares++;
      end
      if (i < 2) tick();
    end
    stall = 1'b0;
    tick();
    vectors++;
    if ({if_valid, if_instr, if_pc, if_plus, req_valid, req_addr} !== {1'b1, 16'h3333, 32'h4, 32'h6, 1'b1, 32'h6}) begin
      $display("FAIL stall_release: got %b/%h/%h/%h req %b/%h want 1/3333/4/6 req 1/6", if_valid, if_instr, if_pc, if_plus, req_valid, req_addr);
      miscompares++;
    end
  endtask

  task automatic test_redirect_wait();
    tick();
    redir = 1'b1; redir_tgt = 32'h0100;
    tick();
    redir = 1'b0; rsp_valid = 1'b1; rsp_data = 16'hDEAD;
    vectors++;
    if ({req_valid, if_valid} !== 2'b00) begin
      $display("FAIL redir_wait_state: got req %b ifid %b want 0/0", req_valid, if_valid); miscompares++;
    end
    tick();
    rsp_valid = 1'b0;
    vectors++;
    if ({if_valid, req_valid, req_addr} !== {1'b0, 1'b1, 32'h0100}) begin
      $display("FAIL redir_drop: got ifid %b req %b/%h want 0 req 1/00000100", if_valid, req_valid, req_addr);
      miscompares++;
    end
    tick();
    rsp_valid = 1'b1; rsp_data = 16'h4444;
    tick();
    rsp_valid = 1'b0;
    vectors++;
    if ({if_valid, if_instr, if_pc, if_plus} !== {1'b1, 16'h4444, 32'h100, 32'h102}) begin
      $display("FAIL redir_target_fetch: got %b/%h/%h/%h want 1/4444/100/102", if_valid, if_instr, if_pc, if_plus);
      miscompares++;
    end
  endtask

  task automatic test_not_ready();
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({req_valid, req_addr, if_valid} !== {1'b1, 32'h102, 1'b0}) begin
        $display("FAIL not_ready[%0d]: got req %b/%h ifid %b want 1/102/0", i, req_valid, req_addr, if_valid);
        miscompares++;
      end
    end
    req_ready = 1'b1;
    tick();
    rsp_valid = 1'b1; rsp_data = 16'h5555;
    vectors++;
    if ({req_valid, if_valid} !== 2'b00) begin
      $display("FAIL not_ready_accept: got req %b ifid %b want 0/0", req_valid, if_valid); miscompares++;
    end
    tick();
    rsp_valid = 1'b0;
    vectors++;
    if ({if_valid, if_instr, if_pc, if_plus} !== {1'b1, 16'h5555, 32'h102, 32'h104}) begin
      $display("FAIL not_ready_load: got %b/%h/%h/%h want 1/5555/102/104", if_valid, if_instr, if_pc, if_plus);
      miscompares++;
    end
  endtask

  task automatic test_wrap();
    rst_b = 1'b1; req_ready_b = 1'b1; rsp_valid_b = 1'b0; rsp_data_b = '0;
    tick();
    rst_b = 1'b0;
    #1;
    vectors++;
    if ({req_valid_b, req_addr_b} !== {1'b1, 32'hFFFF_FFFE}) begin
      $display("FAIL wrap_first_req: got %b/%h want 1/fffffffe", req_valid_b, req_addr_b); miscompares++;
    end
    tick();
    rsp_valid_b = 1'b1; rsp_data_b = 16'h6666;
    tick();
    rsp_valid_b = 1'b0;
    vectors++;
    if ({if_valid_b, if_instr_b, if_pc_b, if_plus_b, req_valid_b, req_addr_b} !== {1'b1, 16'h6666, 32'hFFFF_FFFE, 32'h0, 1'b1, 32'h0}) begin
      $display("FAIL wrap_load: got %b/%h/%h/%h req %b/%h want 1/6666/fffffffe/0 req 1/0", if_valid_b, if_instr_b, if_pc_b, if_plus_b, req_valid_b, req_addr_b);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_wait();
    tick();
    rst = 1'b1;
    #1;
    vectors++;
    if ({req_valid, if_valid, if_instr, if_pc} !== {1'b0, 1'b0, 16'h0, 32'h0}) begin
      $display("FAIL rst_mid_wait: got req %b ifid %b/%h/%h want 0/0/0/0", req_valid, if_valid, if_instr, if_pc);
      miscompares++;
    end
    tick();
    rst = 1'b0; req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 16'hBADD;
    tick();
    vectors++;
    if ({req_valid, req_addr, if_valid} !== {1'b1, 32'h0, 1'b0}) begin
      $display("FAIL late_rsp_ignored: got req %b/%h ifid %b want 1/0/0", req_valid, req_addr, if_valid);
      miscompares++;
    end
    rsp_valid = 1'b0; req_ready = 1'b1;
    tick();
    rsp_valid = 1'b1; rsp_data = 16'h7777;
    vectors++;
    if (if_valid !== 1'b0) begin
      $display("FAIL rst_restart_wait: got ifid %b want 0", if_valid); miscompares++;
    end
    tick();
    rsp_valid = 1'b0;
    vectors++;
    if ({if_valid, if_instr, if_pc, if_plus} !== {1'b1, 16'h7777, 32'h0, 32'h2}) begin
      $display("FAIL rst_restart_load: got %b/%h/%h/%h want 1/7777/0/2", if_valid, if_instr, if_pc, if_plus);
      miscompares++;
    end
  endtask

  task automatic test_redirect_edges();
    redir = 1'b1; redir_tgt = 32'h0200;
    tick();
    redir = 1'b0; rsp_valid = 1'b1; rsp_data = 16'hAAAA;
    vectors++;
    if ({req_valid, if_valid} !== 2'b00) begin
      $display("FAIL redir_on_accept: got req %b ifid %b want 0/0", req_valid, if_valid); miscompares++;
    end
    tick();
    rsp_valid = 1'b0;
    vectors++;
    if ({if_valid, req_valid, req_addr} !== {1'b0, 1'b1, 32'h200}) begin
      $display("FAIL redir_on_accept_drop: got ifid %b req %b/%h want 0 req 1/200", if_valid, req_valid, req_addr);
      miscompares++;
    end
    tick();
    rsp_valid = 1'b1; rsp_data = 16'hBBBB; redir = 1'b1; redir_tgt = 32'h0300;
    tick();
    rsp_valid = 1'b0; redir = 1'b0;
    vectors++;
    if ({if_valid, req_valid, req_addr} !== {1'b0, 1'b1, 32'h300}) begin
      $display("FAIL redir_with_rsp: got ifid %b req %b/%h want 0 req 1/300", if_valid, req_valid, req_addr);
      miscompares++;
    end
    tick();
    rsp_valid = 1'b1; rsp_data = 16'hCCCC;
    tick();
    rsp_valid = 1'b0;
    vectors++;
    if ({if_valid, if_instr, if_pc, if_plus} !== {1'b1, 16'hCCCC, 32'h300, 32'h302}) begin
      $display("FAIL redir_with_rsp_next: got %b/%h/%h/%h want 1/cccc/300/302", if_valid, if_instr, if_pc, if_plus);
      miscompares++;
    end
  endtask

  initial begin
    rst_b = 1'b1; req_ready_b = 1'b0; rsp_valid_b = 1'b0; rsp_data_b = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_not_ready();
    test_wrap();
    test_reset_mid_wait();
    test_redirect_edges();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench did not complete");
  end

endmodule
